encoder_8to3_seq: RTL and testbench

Registered 8-to-3 request encoder, the inverse of the team's 3-to-8 active-low decoder. It watches eight active-low request lines and latches each new request as a pending bit. It then emits the pending requests one at a time as a 3-bit code {A,B,C} under a valid/ready handshake, with multi-request and overrun flags. It sits on the return path of a decoder-driven select bus and turns strobed lines back into a binary index for the consumer.

---
 rtl/encoder_8to3_seq.sv | 62 ++++++
 tb/tb_encoder_8to3_seq.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/encoder_8to3_seq.sv
// encoder_8to3_seq: edge-captured active-low requests served one at a time as a 3-bit code over valid/ready
module encoder_8to3_seq #(
    parameter bit PRIO_HIGH = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [7:0] Y_n,
    input  logic       rdy,
    output logic       A,
    output logic       B,
    output logic       C,
    output logic       vld,
    output logic       multi,
    output logic       ovf
);
    typedef enum logic {IDLE, HOLD} state_t;
    state_t state;
    logic [7:0] y_q, pend, fall, set, served;
    logic [2:0] win;
    logic live, accept;
    // live masks the first cycle after reset so a line held low through reset is not an edge
    always_comb begin
        fall = live ? (y_q & ~Y_n) : '0;
        set = en ? fall : '0;
        accept = (state == HOLD) && rdy;
        served = accept ? (8'b1 << {A, B, C}) : '0;
        win = '0;
        for (int i = 0; i < 8; i++) begin
            if (PRIO_HIGH && pend[i]) win = 3'(i);
            if (!PRIO_HIGH && pend[7-i]) win = 3'(7 - i);
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            y_q <= 8'hFF;
            live <= 1'b0;
            pend <= '0;
            {A, B, C} <= 3'b000;
            vld <= 1'b0;
            multi <= 1'b0;
            ovf <= 1'b0;
            state <= IDLE;
        end else begin
            y_q <= Y_n;
            live <= 1'b1;
            pend <= (pend & ~served) | set;
            if (|(set & pend & ~served)) ovf <= 1'b1;
            if (state == IDLE) begin
                if (|pend) begin
                    {A, B, C} <= win;
                    multi <= |(pend & (pend - 8'd1));
                    vld <= 1'b1;
                    state <= HOLD;
                end
            end else if (rdy) begin
                vld <= 1'b0;
                state <= IDLE;
            end
        end
    end
endmodule

// File: tb/tb_encoder_8to3_seq.sv
// tb_encoder_8to3_seq: scoreboard bench driving both priority orders from shared stimulus
module tb_encoder_8to3_seq;
    logic clk = 1'b0, rst = 1'b1, en = 1'b1, rdy = 1'b1;
    logic [7:0] y_n = 8'h00;
    logic a0, b0, c0, v0, m0, o0;
    logic a1, b1, c1, v1, m1, o1;
    logic [3:0] q0[$], q1[$];
    int n_chk = 0, n_err = 0;

    always #5 clk = ~clk;

    encoder_8to3_seq #(.PRIO_HIGH(1'b1)) dut0 (
        .clk(clk), .rst(rst), .en(en), .Y_n(y_n), .rdy(rdy),
        .A(a0), .B(b0), .C(c0), .vld(v0), .multi(m0), .ovf(o0)
    );
    encoder_8to3_seq #(.PRIO_HIGH(1'b0)) dut1 (
        .clk(clk), .rst(rst), .en(en), .Y_n(y_n), .rdy(rdy),
        .A(a1), .B(b1), .C(c1), .vld(v1), .multi(m1), .ovf(o1)
    );

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [3:0] e0, input logic [3:0] e1);
        q0.push_back(e0);
        q1.push_back(e1);
    endtask

    // each accepted code is popped from its scoreboard as {code, multi}
    always @(negedge clk) begin
        if (!rst && v0 && rdy) begin
            if (q0.size() == 0) check("d0_unexpected_vld", 8'(v0), 8'd0);
            else check("d0_code", 8'({a0, b0, c0, m0}), 8'(q0.pop_front()));
        end
        if (!rst && v1 && rdy) begin
            if (q1.size() == 0) check("d1_unexpected_vld", 8'(v1), 8'd0);
            else check("d1_code", 8'({a1, b1, c1, m1}), 8'(q1.pop_front()));
        end
    end

    initial begin
        tick(2);
        check("rst_vld", 8'(v0), 8'd0);
        check("rst_code", 8'({a0, b0, c0}), 8'd0);
        check("rst_multi", 8'(m0), 8'd0);
        check("rst_ovf", 8'({o0, o1}), 8'd0);
        rst = 1'b0;
        tick(6);
        check("held_low_no_vld", 8'({v0, v1}), 8'd0);
        y_n = 8'hFF;
        tick(3);
        // single request on bit 5
        y_n = 8'hDF;
        push({3'd5, 1'b0}, {3'd5, 1'b0});
        tick(1);
        check("single_not_yet", 8'(v0), 8'd0);
        tick(1);
        check("single_vld", 8'(v0), 8'd1);
        check("single_code", 8'({a0, b0, c0}), 8'd5);
        tick(1);
        check("single_bubble", 8'(v0), 8'd0);
        tick(6);
        y_n = 8'hFF;
        tick(2);
        // bits 2 and 6 together
        y_n = 8'hBB;
        push({3'd6, 1'b1}, {3'd2, 1'b1});
        push({3'd2, 1'b0}, {3'd6, 1'b0});
        tick(3);
        check("prio_bubble", 8'({v0, v1}), 8'd0);
        tick(1);
        check("prio_second_vld", 8'({v0, v1}), 8'h3);
        tick(4);
        y_n = 8'hFF;
        tick(2);
        // backpressure on bit 3
        rdy = 1'b0;
        y_n = 8'hF7;
        push({3'd3, 1'b0}, {3'd3, 1'b0});
        tick(2);
        for (int i = 0; i < 10; i++) begin
            check("bp_vld", 8'(v0), 8'd1);
            check("bp_code", 8'({a0, b0, c0}), 8'd3);
            tick(1);
        end
        rdy = 1'b1;
        tick(1);
        check("bp_after_accept", 8'(v0), 8'd0);
        y_n = 8'hFF;
        tick(3);
        // bit 1 re-falls in the accept cycle
        rdy = 1'b0;
        y_n = 8'hFD;
        push({3'd1, 1'b0}, {3'd1, 1'b0});
        push({3'd1, 1'b0}, {3'd1, 1'b0});
        tick(2);
        y_n = 8'hFF;
        tick(1);
        y_n = 8'hFD;
        rdy = 1'b1;
        tick(1);
        check("retrig_ovf", 8'({o0, o1}), 8'd0);
        check("retrig_bubble", 8'(v0), 8'd0);
        tick(1);
        check("retrig_second_vld", 8'(v0), 8'd1);
        tick(3);
        y_n = 8'hFF;
        tick(2);
        // bit 4 re-falls while pending and not served
        rdy = 1'b0;
        y_n = 8'hEF;
        push({3'd4, 1'b0}, {3'd4, 1'b0});
        tick(2);
        y_n = 8'hFF;
        tick(1);
        check("ovf_before", 8'({o0, o1}), 8'd0);
        y_n = 8'hEF;
        tick(1);
        check("ovf_set", 8'({o0, o1}), 8'h3);
        rdy = 1'b1;
        tick(5);
        check("ovf_sticky", 8'({o0, o1}), 8'h3);
        y_n = 8'hFF;
        tick(2);
        // disabled capture on bit 7
        en = 1'b0;
        y_n = 8'h7F;
        tick(5);
        en = 1'b1;
        tick(4);
        check("en_no_vld", 8'({v0, v1}), 8'd0);
        y_n = 8'hFF;
        tick(2);
        // reset while code 000 is held
        rdy = 1'b0;
        y_n = 8'hFE;
        tick(2);
        check("mid_vld", 8'(v0), 8'd1);
        check("mid_code", 8'({a0, b0, c0}), 8'd0);
        rst = 1'b1;
        tick(2);
        check("mid_rst_vld", 8'({v0, v1}), 8'd0);
        check("mid_rst_ovf", 8'({o0, o1}), 8'd0);
        rst = 1'b0;
        rdy = 1'b1;
        tick(6);
        check("mid_no_code", 8'({v0, v1}), 8'd0);
        check("q0_drained", 8'(q0.size()), 8'd0);
        check("q1_drained", 8'(q1.size()), 8'd0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
